// File: rtl/sdram_mem_arbiter_if.sv
// Requester-side and SDRAM-controller-side signals of the memory arbiter.
// The slave view is the arbiter itself (it serves the requesters and drives
// the controller port); the master view is the surrounding system.
interface sdram_mem_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
);
  localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BE_BITS  = DATA_BITS / 8;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           req_read0_write1;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ*BE_BITS-1:0]   req_byteenable;
  logic [NUM_REQ*DATA_BITS-1:0] req_write_data;
  logic [NUM_REQ-1:0]           req_ack;
  logic                         req_err;
  logic [DATA_BITS-1:0]         req_read_data;
  logic [IDX_BITS-1:0]          grant_idx;
  logic                         busy;

  logic                         mem_cs;
  logic                         mem_read0_write1;
  logic [ADDR_BITS-1:0]         mem_addr;
  logic [BE_BITS-1:0]           mem_byteenable;
  logic [DATA_BITS-1:0]         mem_write_data;
  logic                         mem_ack;
  logic [DATA_BITS-1:0]         mem_read_data;

  modport slave (
    input  req, req_read0_write1, req_addr, req_byteenable, req_write_data,
    input  mem_ack, mem_read_data,
    output req_ack, req_err, req_read_data, grant_idx, busy,
    output mem_cs, mem_read0_write1, mem_addr, mem_byteenable, mem_write_data
  );

  modport master (
    output req, req_read0_write1, req_addr, req_byteenable, req_write_data,
    output mem_ack, mem_read_data,
    input  req_ack, req_err, req_read_data, grant_idx, busy,
    input  mem_cs, mem_read0_write1, mem_addr, mem_byteenable, mem_write_data
  );
endinterface

// File: rtl/sdram_mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between NUM_REQ
// requesters. One transaction is outstanding at a time; a watchdog forces
// completion (with req_err) when the controller never acknowledges.
module sdram_mem_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_BITS      = 24,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  sdram_mem_arbiter_if.slave bus
);

  localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BE_BITS  = DATA_BITS / 8;
  localparam int WD_BITS  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RELEASE
  } state_t;

  state_t              state;
  logic [WD_BITS-1:0]  wd_cnt;
  logic [IDX_BITS-1:0] winner;
  logic                found;

  // Index k positions after base, wrapping at NUM_REQ.
  function automatic logic [IDX_BITS-1:0] rr_next(input logic [IDX_BITS-1:0] base,
                                                  input int k);
    return IDX_BITS'((int'(base) + k) % NUM_REQ);
  endfunction

  // Round-robin search starting just after the last winner, so the previous winner is checked last.
  always_comb begin
    found  = 1'b0;
    winner = bus.grant_idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req[rr_next(bus.grant_idx, k)]) begin
        found  = 1'b1;
        winner = rr_next(bus.grant_idx, k);
      end
    end
  end

  // Arbitration FSM with registered outputs; sync_reset clears everything exactly like reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      wd_cnt               <= '0;
      bus.grant_idx        <= IDX_BITS'(NUM_REQ - 1);
      bus.busy             <= 1'b0;
      bus.req_ack          <= '0;
      bus.req_err          <= 1'b0;
      bus.req_read_data    <= '0;
      bus.mem_cs           <= 1'b0;
      bus.mem_read0_write1 <= 1'b0;
      bus.mem_addr         <= '0;
      bus.mem_byteenable   <= '0;
      bus.mem_write_data   <= '0;
    end else if (sync_reset) begin
      state                <= S_IDLE;
      wd_cnt               <= '0;
      bus.grant_idx        <= IDX_BITS'(NUM_REQ - 1);
      bus.busy             <= 1'b0;
      bus.req_ack          <= '0;
      bus.req_err          <= 1'b0;
      bus.req_read_data    <= '0;
      bus.mem_cs           <= 1'b0;
      bus.mem_read0_write1 <= 1'b0;
      bus.mem_addr         <= '0;
      bus.mem_byteenable   <= '0;
      bus.mem_write_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            bus.grant_idx        <= winner;
            bus.mem_read0_write1 <= bus.req_read0_write1[winner];
            bus.mem_addr         <= bus.req_addr[int'(winner)*ADDR_BITS +: ADDR_BITS];
            bus.mem_byteenable   <= bus.req_byteenable[int'(winner)*BE_BITS +: BE_BITS];
            bus.mem_write_data   <= bus.req_write_data[int'(winner)*DATA_BITS +: DATA_BITS];
            bus.mem_cs           <= 1'b1;
            bus.busy             <= 1'b1;
            state                <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.mem_cs <= 1'b0;
          wd_cnt     <= '0;
          state      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (bus.mem_ack) begin
            bus.req_read_data <= bus.mem_read_data;
            bus.req_ack       <= NUM_REQ'(1) << bus.grant_idx;
            bus.req_err       <= 1'b0;
            state             <= S_RELEASE;
          end else if (wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
            bus.req_read_data <= '0;
            bus.req_ack       <= NUM_REQ'(1) << bus.grant_idx;
            bus.req_err       <= 1'b1;
            state             <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          bus.req_ack <= '0;
          bus.req_err <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_mem_arbiter.sv
// Self-checking bench for sdram_mem_arbiter: a cycle-stepped requester and
// controller model with scoreboard queues for issued payloads and acks.
module tb_sdram_mem_arbiter;

  localparam int NUM_REQ        = 3;
  localparam int ADDR_BITS      = 24;
  localparam int DATA_BITS      = 32;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int BE_BITS        = DATA_BITS / 8;
  localparam int IDX_BITS       = 2;

  typedef struct {
    int                   idx;
    logic                 wr;
    logic [ADDR_BITS-1:0] addr;
    logic [BE_BITS-1:0]   be;
    logic [DATA_BITS-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int                   idx;
    logic                 err;
    logic                 chk;
    logic [DATA_BITS-1:0] rdata;
  } ack_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_reset = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cs_count = 0;
  int ack_count = 0;
  int cs_cyc = 0;
  int ack_cyc = 0;
  int ctl_delay = 0;
  int ctl_cnt = 0;
  logic [DATA_BITS-1:0] ctl_rdata = '0;
  logic [NUM_REQ-1:0] hold = '0;
  bit outstanding = 1'b0;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];

  sdram_mem_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)
  ) bus ();

  sdram_mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the bench itself loses track.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] global timeout");
  end

  function automatic mem_exp_t make_txn(int i, logic wr, logic [ADDR_BITS-1:0] a,
                                        logic [BE_BITS-1:0] be, logic [DATA_BITS-1:0] d);
    mem_exp_t p;
    p.idx = i; p.wr = wr; p.addr = a; p.be = be; p.wdata = d;
    return p;
  endfunction

  function automatic mem_exp_t rr_payload(int i);
    return make_txn(i, i[0], ADDR_BITS'(32'h1000 + 16 * i), BE_BITS'(1 << i),
                    DATA_BITS'(32'hA000_0000 + i));
  endfunction

  task automatic set_req(input mem_exp_t p);
    bus.req[p.idx]                                   = 1'b1;
    bus.req_read0_write1[p.idx]                      = p.wr;
    bus.req_addr[p.idx*ADDR_BITS +: ADDR_BITS]       = p.addr;
    bus.req_byteenable[p.idx*BE_BITS +: BE_BITS]     = p.be;
    bus.req_write_data[p.idx*DATA_BITS +: DATA_BITS] = p.wdata;
  endtask

  // One clock: sample at negedge, run controller/requester models, score outputs.
  task automatic tick();
    mem_exp_t me;
    ack_exp_t ae;
    logic [NUM_REQ-1:0] exp_ack;
    @(negedge clk);
    cyc++;
    bus.mem_ack = 1'b0;
    if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        bus.mem_ack = 1'b1;
        bus.mem_read_data = ctl_rdata;
      end
    end
    if (bus.mem_cs === 1'b1) begin
      cs_count++;
      cs_cyc = cyc;
      total++;
      if (outstanding || mem_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL cs_unexpected: mem_cs at cycle %0d outstanding=%0d queued=%0d, required none",
                 cyc, outstanding, mem_q.size());
      end else begin
        me = mem_q.pop_front();
        if ({bus.grant_idx, bus.mem_read0_write1, bus.mem_addr, bus.mem_byteenable, bus.mem_write_data}
            !== {me.idx[IDX_BITS-1:0], me.wr, me.addr, me.be, me.wdata}) begin
          bad++;
          $display("[TB] FAIL cs_payload: got g=%0d w=%b a=%h be=%h d=%h, required g=%0d w=%b a=%h be=%h d=%h",
                   bus.grant_idx, bus.mem_read0_write1, bus.mem_addr, bus.mem_byteenable,
                   bus.mem_write_data, me.idx, me.wr, me.addr, me.be, me.wdata);
        end
      end
      outstanding = 1'b1;
      if (ctl_delay > 0) ctl_cnt = ctl_delay;
    end
    if (bus.req_ack !== '0) begin
      ack_count++;
      ack_cyc = cyc;
      outstanding = 1'b0;
      total++;
      if (ack_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL ack_unexpected: req_ack=%b at cycle %0d, required 0", bus.req_ack, cyc);
      end else begin
        ae = ack_q.pop_front();
        exp_ack = '0;
        exp_ack[ae.idx] = 1'b1;
        if ({bus.req_ack, bus.req_err, bus.grant_idx} !== {exp_ack, ae.err, ae.idx[IDX_BITS-1:0]}) begin
          bad++;
          $display("[TB] FAIL ack_flags: got ack=%b err=%b g=%0d, required ack=%b err=%b g=%0d",
                   bus.req_ack, bus.req_err, bus.grant_idx, exp_ack, ae.err, ae.idx);
        end
        if (ae.chk) begin
          total++;
          if (bus.req_read_data !== ae.rdata) begin
            bad++;
            $display("[TB] FAIL ack_rdata: got %h, required %h", bus.req_read_data, ae.rdata);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ack[i] && !hold[i]) bus.req[i] = 1'b0;
    end
  endtask

  task automatic wait_ack(input string name);
    int start = ack_count;
    int n = 0;
    while (ack_count == start && n < 200) begin
      tick();
      n++;
    end
    if (ack_count == start) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_ack_wait: no req_ack within 200 cycles, required one", name);
    end
  endtask

  task automatic wait_cs(input string name);
    int start = cs_count;
    int n = 0;
    while (cs_count == start && n < 50) begin
      tick();
      n++;
    end
    if (cs_count == start) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_cs_wait: no mem_cs within 50 cycles, required one", name);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = '0;
    hold = '0;
    ctl_cnt = 0;
    outstanding = 1'b0;
    mem_q.delete();
    ack_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    total++;
    if ({bus.mem_cs, bus.req_ack, bus.req_err, bus.busy} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: cs=%b ack=%b err=%b busy=%b, required all 0",
               bus.mem_cs, bus.req_ack, bus.req_err, bus.busy);
    end
    total++;
    if (bus.grant_idx !== IDX_BITS'(NUM_REQ - 1)) begin
      bad++;
      $display("[TB] FAIL reset_grant: got %0d, required %0d", bus.grant_idx, NUM_REQ - 1);
    end
    total++;
    if ({bus.mem_read0_write1, bus.mem_addr, bus.mem_byteenable, bus.mem_write_data, bus.req_read_data} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_payload: a=%h be=%h d=%h rd=%h, required 0",
               bus.mem_addr, bus.mem_byteenable, bus.mem_write_data, bus.req_read_data);
    end
    reset_n = 1'b1;
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.mem_cs !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: busy=%b cs=%b, required 0 0", bus.busy, bus.mem_cs);
    end
  endtask

  task automatic test_single_write();
    mem_exp_t p = make_txn(1, 1'b1, 24'h000100, 4'hF, 32'hDEADBEEF);
    int c0 = cs_count;
    ctl_delay = 3;
    ctl_rdata = 32'h0;
    set_req(p);
    mem_q.push_back(p);
    ack_q.push_back('{idx: 1, err: 1'b0, chk: 1'b0, rdata: '0});
    wait_ack("single_write");
    total++;
    if (ack_cyc - cs_cyc != 4) begin
      bad++;
      $display("[TB] FAIL write_latency: cs-to-ack %0d cycles, required 4", ack_cyc - cs_cyc);
    end
    total++;
    if (cs_count - c0 != 1 || bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL write_release: cs count %0d busy=%b, required 1 and 1", cs_count - c0, bus.busy);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.req_ack !== '0 || bus.req_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_idle: busy=%b ack=%b err=%b, required 0", bus.busy, bus.req_ack, bus.req_err);
    end
    total++;
    if (bus.mem_addr !== 24'h000100 || bus.mem_write_data !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL write_hold: a=%h d=%h, required 000100 deadbeef", bus.mem_addr, bus.mem_write_data);
    end
  endtask

  task automatic test_read();
    mem_exp_t p = make_txn(0, 1'b0, 24'h0002A0, 4'hF, 32'h0);
    ctl_delay = 2;
    ctl_rdata = 32'h12345678;
    set_req(p);
    mem_q.push_back(p);
    ack_q.push_back('{idx: 0, err: 1'b0, chk: 1'b1, rdata: 32'h12345678});
    wait_ack("read");
    total++;
    if (ack_cyc - cs_cyc != 3) begin
      bad++;
      $display("[TB] FAIL read_latency: cs-to-ack %0d cycles, required 3", ack_cyc - cs_cyc);
    end
    tick();
    total++;
    if (bus.grant_idx !== 2'd0) begin
      bad++;
      $display("[TB] FAIL read_grant: got %0d, required 0", bus.grant_idx);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    do_reset();
    c0 = cs_count;
    hold = '1;
    for (int i = 0; i < NUM_REQ; i++) set_req(rr_payload(i));
    for (int n = 0; n < 6; n++) begin
      mem_q.push_back(rr_payload(n % NUM_REQ));
      ack_q.push_back('{idx: n % NUM_REQ, err: 1'b0, chk: 1'b1, rdata: DATA_BITS'(32'h5000_0000 + n)});
    end
    for (int n = 0; n < 6; n++) begin
      ctl_delay = 1 + n % 3;
      ctl_rdata = DATA_BITS'(32'h5000_0000 + n);
      wait_ack("round_robin");
      total++;
      if (ack_cyc - cs_cyc != ctl_delay + 1) begin
        bad++;
        $display("[TB] FAIL rr_latency: txn %0d cs-to-ack %0d, required %0d", n, ack_cyc - cs_cyc, ctl_delay + 1);
      end
    end
    bus.req = '0;
    hold = '0;
    tick();
    tick();
    total++;
    if (cs_count - c0 != 6 || mem_q.size() != 0 || ack_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rr_count: cs=%0d left mem=%0d ack=%0d, required 6 0 0",
               cs_count - c0, mem_q.size(), ack_q.size());
    end
  endtask

  task automatic test_timeout();
    mem_exp_t p = make_txn(2, 1'b0, 24'hABCDE0, 4'hC, 32'h0);
    mem_exp_t q = make_txn(0, 1'b1, 24'h000444, 4'h3, 32'h11223344);
    ctl_delay = 0;
    ctl_rdata = 32'h99999999;
    bus.mem_read_data = 32'h99999999;
    set_req(p);
    mem_q.push_back(p);
    ack_q.push_back('{idx: 2, err: 1'b1, chk: 1'b1, rdata: '0});
    wait_ack("timeout");
    total++;
    if (ack_cyc - cs_cyc != TIMEOUT_CYCLES + 1) begin
      bad++;
      $display("[TB] FAIL timeout_len: cs-to-ack %0d, required %0d", ack_cyc - cs_cyc, TIMEOUT_CYCLES + 1);
    end
    tick();
    ctl_delay = 2;
    set_req(q);
    mem_q.push_back(q);
    ack_q.push_back('{idx: 0, err: 1'b0, chk: 1'b0, rdata: '0});
    wait_ack("after_timeout");
    total++;
    if (ack_cyc - cs_cyc != 3) begin
      bad++;
      $display("[TB] FAIL after_timeout_latency: cs-to-ack %0d, required 3", ack_cyc - cs_cyc);
    end
    tick();
  endtask

  task automatic test_coincide();
    mem_exp_t p = make_txn(1, 1'b0, 24'h00F00F, 4'hF, 32'h0);
    ctl_delay = TIMEOUT_CYCLES;
    ctl_rdata = 32'hCAFEF00D;
    set_req(p);
    mem_q.push_back(p);
    ack_q.push_back('{idx: 1, err: 1'b0, chk: 1'b1, rdata: 32'hCAFEF00D});
    wait_ack("coincide");
    total++;
    if (ack_cyc - cs_cyc != TIMEOUT_CYCLES + 1) begin
      bad++;
      $display("[TB] FAIL coincide_len: cs-to-ack %0d, required %0d", ack_cyc - cs_cyc, TIMEOUT_CYCLES + 1);
    end
    tick();
  endtask

  task automatic test_stray_ack();
    int c0 = ack_count;
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_read_data = 32'hFFFF0000;
    repeat (4) tick();
    total++;
    if (ack_count != c0 || bus.busy !== 1'b0 || bus.req_read_data !== 32'hCAFEF00D) begin
      bad++;
      $display("[TB] FAIL stray_ack: acks %0d busy=%b rd=%h, required 0 0 cafef00d",
               ack_count - c0, bus.busy, bus.req_read_data);
    end
  endtask

  task automatic test_sync_reset();
    mem_exp_t p = make_txn(0, 1'b1, 24'h000777, 4'hF, 32'h77777777);
    int c0;
    ctl_delay = 0;
    set_req(p);
    mem_q.push_back(p);
    wait_cs("sync_reset");
    tick();
    tick();
    c0 = ack_count;
    sync_reset = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.req_ack !== '0 || bus.mem_cs !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sync_reset_state: busy=%b ack=%b cs=%b, required 0", bus.busy, bus.req_ack, bus.mem_cs);
    end
    total++;
    if (bus.grant_idx !== IDX_BITS'(NUM_REQ - 1)) begin
      bad++;
      $display("[TB] FAIL sync_reset_grant: got %0d, required %0d", bus.grant_idx, NUM_REQ - 1);
    end
    sync_reset = 1'b0;
    bus.req = '0;
    outstanding = 1'b0;
    repeat (TIMEOUT_CYCLES + 4) tick();
    total++;
    if (ack_count != c0) begin
      bad++;
      $display("[TB] FAIL sync_reset_noack: %0d acks, required 0", ack_count - c0);
    end
  endtask

  task automatic test_async_reset();
    mem_exp_t p = make_txn(1, 1'b0, 24'h000888, 4'hF, 32'h0);
    mem_exp_t q = make_txn(0, 1'b1, 24'h000999, 4'h5, 32'h55AA55AA);
    ctl_delay = 0;
    set_req(p);
    mem_q.push_back(p);
    wait_cs("async_reset");
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.mem_cs !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_cs: cs=%b busy=%b, required 0 0", bus.mem_cs, bus.busy);
    end
    #1;
    reset_n = 1'b1;
    bus.req = '0;
    outstanding = 1'b0;
    repeat (3) tick();
    ctl_delay = 1;
    set_req(q);
    mem_q.push_back(q);
    ack_q.push_back('{idx: 0, err: 1'b0, chk: 1'b0, rdata: '0});
    wait_ack("after_async_reset");
    tick();
    total++;
    if (bus.busy !== 1'b0 || mem_q.size() != 0 || ack_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL async_recover: busy=%b mem=%0d ack=%0d, required 0 0 0",
               bus.busy, mem_q.size(), ack_q.size());
    end
  endtask

  // Test sequence.
  initial begin
    bus.req = '0;
    bus.req_read0_write1 = '0;
    bus.req_addr = '0;
    bus.req_byteenable = '0;
    bus.req_write_data = '0;
    bus.mem_ack = 1'b0;
    bus.mem_read_data = '0;
    test_reset();
    test_single_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_coincide();
    test_stray_ack();
    test_sync_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
